// File: rtl/key_switch_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// key_cond_pkg
// Shared types and constants for the KEY/SW input conditioner.
//   key_state_t             : per-key debounce FSM states
//   DEFAULT_DEBOUNCE_CYCLES : default stable-cycle count to accept a key change
//   cnt_width()             : debounce counter width for a given cycle count
// -----------------------------------------------------------------------------
package key_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage : key_cond_pkg

// File: rtl/key_switch_conditioner_if.sv
// -----------------------------------------------------------------------------
// key_switch_conditioner_if
// Bundle of board-side inputs and peripheral-side outputs of the conditioner.
//   key_n       : raw active-low keys
//   sw_raw      : raw slide switches
//   pending_clr : per-key clear strobe for btn_pending
//   sw_sync     : synchronised switches
//   btn_level   : debounced key level (1 = pressed)
//   btn_press   : one-cycle pulse on accepted press
//   btn_pending : sticky press flags
//   irq         : OR of pending flags, only when KEYCOND_IRQ_EN is defined
// Modports: master drives the inputs (board/bench), slave is the conditioner.
// -----------------------------------------------------------------------------
interface key_switch_conditioner_if #(
  parameter int NUM_KEYS = 2,
  parameter int NUM_SW   = 10
);
  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_SW-1:0]   sw_raw;
  logic [NUM_KEYS-1:0] pending_clr;
  logic [NUM_SW-1:0]   sw_sync;
  logic [NUM_KEYS-1:0] btn_level;
  logic [NUM_KEYS-1:0] btn_press;
  logic [NUM_KEYS-1:0] btn_pending;
`ifdef KEYCOND_IRQ_EN
  logic                irq;
`endif

  modport master (
    output key_n, sw_raw, pending_clr,
`ifdef KEYCOND_IRQ_EN
    input  irq,
`endif
    input  sw_sync, btn_level, btn_press, btn_pending
  );

  modport slave (
    input  key_n, sw_raw, pending_clr,
`ifdef KEYCOND_IRQ_EN
    output irq,
`endif
    output sw_sync, btn_level, btn_press, btn_pending
  );

endinterface : key_switch_conditioner_if

// File: rtl/key_switch_conditioner_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One push-button channel: two-flop synchroniser, debounce FSM with counter,
// registered debounced level and one-cycle press pulse.
//   HCLK, HRESETn : clock, async active-low reset
//   key_n         : raw active-low key
//   level         : debounced level, 1 while PRESSED or RELEASE_WAIT
//   press         : one-cycle pulse on PRESS_WAIT -> PRESSED
// -----------------------------------------------------------------------------
module key_debounce
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic key_n,
  output logic level,
  output logic press
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  // The RELEASED->PRESS_WAIT (or PRESSED->RELEASE_WAIT) step already consumed
  // one stable sample, so the wait state terminates one count early. This gives
  // exactly DEBOUNCE_CYCLES stable samples and a level change DEBOUNCE_CYCLES+1
  // edges after the synchroniser first captures the new value.
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 2);

  logic [1:0]    sync_q, sync_d;
  key_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          k;

  // Synchroniser shift, first stage samples the pin.
  always_comb begin
    sync_d = {sync_q[0], key_n};
  end

  assign k = ~sync_q[1];

  // Debounce FSM next-state, counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (k) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = RELEASED;
        end
      end
      PRESS_WAIT: begin
        if (!k) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == TERM) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!k) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = PRESSED;
        end
      end
      RELEASE_WAIT: begin
        if (k) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == TERM) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  // State, counter, synchroniser and output registers; keys reset released.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync_q  <= 2'b11;
      state_q <= RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule : key_debounce

// File: rtl/key_switch_conditioner.sv
// -----------------------------------------------------------------------------
// key_switch_conditioner
// Conditions DE1-SoC KEY/SW pins for the button/switch peripheral.
//   HCLK, HRESETn : system clock, async active-low reset
//   bus (slave)   : key_n, sw_raw, pending_clr in; sw_sync, btn_level,
//                   btn_press, btn_pending out (all outputs registered)
// Optional: define KEYCOND_IRQ_EN to add bus.irq = |btn_pending, one cycle late.
// -----------------------------------------------------------------------------
module key_switch_conditioner
  import key_cond_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int NUM_SW          = 10,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  key_switch_conditioner_if.slave bus
);
  logic [NUM_SW-1:0]   sw_meta_q, sw_meta_d;
  logic [NUM_SW-1:0]   sw_sync_q, sw_sync_d;
  logic [NUM_KEYS-1:0] pending_q, pending_d;
  logic [NUM_KEYS-1:0] level_w;
  logic [NUM_KEYS-1:0] press_w;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .key_n   (bus.key_n[i]),
      .level   (level_w[i]),
      .press   (press_w[i])
    );
  end

  // Switch synchroniser and pending flags; a press in the same cycle as a
  // clear keeps the flag set.
  always_comb begin
    sw_meta_d = bus.sw_raw;
    sw_sync_d = sw_meta_q;
    pending_d = press_w | (pending_q & ~bus.pending_clr);
  end

  // Switch synchroniser and pending flag registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      pending_q <= '0;
    end else begin
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      pending_q <= pending_d;
    end
  end

  assign bus.sw_sync     = sw_sync_q;
  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_pending = pending_q;

`ifdef KEYCOND_IRQ_EN
  logic irq_q, irq_d;

  // Interrupt request is the pending summary, one cycle behind.
  always_comb begin
    irq_d = |pending_q;
  end

  // Interrupt request register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign bus.irq = irq_q;
`endif

endmodule : key_switch_conditioner

// File: tb/tb_key_switch_conditioner.sv
// Directed bench for key_switch_conditioner (NUM_KEYS=2, NUM_SW=10,
// DEBOUNCE_CYCLES=16). Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point, so "tick n" observes edge n.
module tb_key_switch_conditioner;
  logic HCLK;
  logic HRESETn;
  int   total;
  int   bad;
  logic [9:0] prev_sw;
  logic [9:0] sw_vals [11];

  key_switch_conditioner_if #(.NUM_KEYS(2), .NUM_SW(10)) bus ();

  key_switch_conditioner #(
    .NUM_KEYS        (2),
    .NUM_SW          (10),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial HCLK = 1'b0;
  always #10 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    sw_vals = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8, 10'd15, 10'd12};

    // Reset state and switch synchroniser latency out of reset.
    HRESETn         = 1'b0;
    bus.key_n       = 2'b11;
    bus.sw_raw      = 10'h001;
    bus.pending_clr = 2'b00;
    repeat (3) tick();
    chk("rst_sw_sync", 32'(bus.sw_sync), 32'h0);
    chk("rst_level", 32'(bus.btn_level), 32'h0);
    chk("rst_press", 32'(bus.btn_press), 32'h0);
    chk("rst_pending", 32'(bus.btn_pending), 32'h0);
`ifdef KEYCOND_IRQ_EN
    chk("rst_irq", 32'(bus.irq), 32'h0);
`endif
    HRESETn = 1'b1;
    tick();
    chk("sw_after_edge1", 32'(bus.sw_sync), 32'h0);
    tick();
    chk("sw_after_edge2", 32'(bus.sw_sync), 32'h001);
    chk("idle_level", 32'(bus.btn_level), 32'h0);
    chk("idle_pending", 32'(bus.btn_pending), 32'h0);

    // Key 0 held for 50 cycles: level rises at edge 18, one press pulse.
    bus.key_n = 2'b10;
    repeat (17) tick();
    chk("k0_level_e17", 32'(bus.btn_level[0]), 32'h0);
    tick();
    chk("k0_level_e18", 32'(bus.btn_level[0]), 32'h1);
    chk("k0_press_e18", 32'(bus.btn_press), 32'h1);
    chk("k0_pending_e18", 32'(bus.btn_pending[0]), 32'h0);
    tick();
    chk("k0_press_e19", 32'(bus.btn_press[0]), 32'h0);
    chk("k0_pending_e19", 32'(bus.btn_pending), 32'h1);
`ifdef KEYCOND_IRQ_EN
    chk("irq_e19", 32'(bus.irq), 32'h0);
`endif
    tick();
`ifdef KEYCOND_IRQ_EN
    chk("irq_e20", 32'(bus.irq), 32'h1);
`endif
    chk("k0_level_hold", 32'(bus.btn_level[0]), 32'h1);
    repeat (30) tick();

    // Release: no pulse, level falls at edge 18 after the release.
    bus.key_n = 2'b11;
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk("k0_rel_no_press", 32'(bus.btn_press[0]), 32'h0);
    end
    chk("k0_rel_level_e17", 32'(bus.btn_level[0]), 32'h1);
    tick();
    chk("k0_rel_level_e18", 32'(bus.btn_level[0]), 32'h0);

    // Key 1 glitch of 10 cycles is rejected.
    bus.key_n = 2'b01;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("k1_glitch_low", 32'({bus.btn_level[1], bus.btn_press[1], bus.btn_pending[1]}), 32'h0);
    end
    bus.key_n = 2'b11;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("k1_glitch_high", 32'({bus.btn_level[1], bus.btn_press[1], bus.btn_pending[1]}), 32'h0);
    end

    // New key 0 press with a clear in the press cycle: set wins.
    bus.key_n = 2'b10;
    repeat (18) tick();
    chk("k0_press2", 32'(bus.btn_press[0]), 32'h1);
    bus.pending_clr = 2'b01;
    tick();
    bus.pending_clr = 2'b00;
    chk("set_wins", 32'(bus.btn_pending[0]), 32'h1);
    bus.pending_clr = 2'b01;
    tick();
    bus.pending_clr = 2'b00;
    chk("clear_alone", 32'(bus.btn_pending[0]), 32'h0);
    repeat (5) tick();
    chk("held_no_reset", 32'(bus.btn_pending[0]), 32'h0);
    chk("held_level", 32'(bus.btn_level[0]), 32'h1);
    bus.key_n = 2'b11;
    repeat (18) tick();
    chk("k0_rel2_level", 32'(bus.btn_level[0]), 32'h0);

    // Reset 8 cycles into a press, released while the key is still held.
    bus.key_n = 2'b10;
    repeat (8) tick();
    HRESETn = 1'b0;
    #1;
    chk("midrst_sw_sync", 32'(bus.sw_sync), 32'h0);
    chk("midrst_level", 32'(bus.btn_level), 32'h0);
    repeat (3) tick();
    chk("midrst_press", 32'(bus.btn_press), 32'h0);
    chk("midrst_pending", 32'(bus.btn_pending), 32'h0);
    HRESETn = 1'b1;
    repeat (17) tick();
    chk("postrst_press_e17", 32'(bus.btn_press[0]), 32'h0);
    tick();
    chk("postrst_press_e18", 32'(bus.btn_press[0]), 32'h1);
    chk("postrst_level_e18", 32'(bus.btn_level[0]), 32'h1);
    bus.key_n = 2'b11;
    repeat (18) tick();
    chk("postrst_rel_level", 32'(bus.btn_level[0]), 32'h0);

    // Switch sweep: old value after one edge, new value after two.
    prev_sw = 10'h001;
    for (int i = 0; i < 11; i++) begin
      bus.sw_raw = sw_vals[i];
      tick();
      chk("sw_lat1", 32'(bus.sw_sync), 32'(prev_sw));
      tick();
      chk("sw_lat2", 32'(bus.sw_sync), 32'(sw_vals[i]));
      prev_sw = sw_vals[i];
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_key_switch_conditioner
